icache_fetch_responder: RTL and testbench
=========================================

// Module: icache_fetch_responder
// PURPOSE
// - Instruction-cache side of the fetch interface: takes current_PC from the IF stage and returns
//   Hit_cache, Miss, partial_access, partial_type and fetched_data in the same cycle.
// - Direct-mapped, register-array cache. Misses are refilled from the next memory level through a
//   valid/ready request channel and a single-beat response.
// PARAMETERS
// - PC_BITS      32   fetch address width
// - FETCH_WIDTH  64   fetch window in bits (8 bytes, little-endian: fetched_data[7:0] = byte at PC)
// - LINE_BITS    256  cache line width (32 bytes); power of two, >= FETCH_WIDTH
// - LINES        64   number of lines; power of two
// PORTS
// - clk             in   1            clock
// - rst_n           in   1            asynchronous active-low reset
// - current_PC      in   PC_BITS      fetch address from IF; halfword aligned
// - Hit_cache       out  1            lookup hit this cycle
// - Miss            out  1            lookup missed or refill in progress
// - partial_access  out  1            fetch window crosses the line end; only the low bytes are valid
// - partial_type    out  2            valid bytes/2: 01=2B, 10=4B, 11=6B; 00 when not partial
// - fetched_data    out  FETCH_WIDTH  bytes at PC; invalid bytes driven 0
// - invalidate_all  in   1            clear all valid bits (fence.i)
// - mem_req_valid   out  1            refill request
// - mem_req_ready   in   1            memory accepts request
// - mem_req_addr    out  PC_BITS      line-aligned refill address
// - mem_resp_valid  in   1            refill data valid
// - mem_resp_data   in   LINE_BITS    full line
// BEHAVIOUR
// - Address split: offset = PC[OB-1:0] with OB = log2(LINE_BITS/8); index = PC[OB +: log2(LINES)];
//   tag = remaining upper bits. Arrays: valid[LINES], tag[LINES], data[LINES].
// - Lookup is combinational on current_PC. Hit_cache = (state==IDLE) & valid[index] & tag match.
//   Miss = ~Hit_cache. Outputs are meaningful only on hit.
// - Partial access: bytes left in the line = LINE_BYTES - offset. If this is < 8, partial_access=1,
//   partial_type = bytes left / 2, and the remaining upper bytes are zeroed. Otherwise the access is
//   full and partial_type=00. The IF stage then fetches the next line address separately.
// - FSM states: IDLE, REQ, WAIT, FILL.
//   - IDLE: on lookup miss, latch the line address (PC with offset cleared) and go to REQ next cycle.
//   - REQ: mem_req_valid=1 with mem_req_addr held stable until mem_req_ready, then go to WAIT.
//     If mem_req_ready is already high on entry, the handshake completes in that cycle.
//   - WAIT: on mem_resp_valid, capture mem_resp_data and go to FILL.
//   - FILL: write data and tag, set valid at the latched index, return to IDLE.
//     Lookup of the refilled line hits the first cycle back in IDLE.
// - Refill latency: miss cycle + REQ(>=1) + WAIT(>=1) + FILL(1); hit at the earliest 4 cycles after the miss cycle.
// - The refill completes for the latched address even if current_PC changes meanwhile; the new PC is
//   looked up after returning to IDLE.
// - invalidate_all: all valid bits clear at the next edge.
//   - In FILL, invalidate wins: the valid bit is not set and the data is discarded.
//   - In REQ/WAIT, the refill continues to completion, but its valid bit stays clear.
//   - Simultaneous invalidate and IDLE lookup: that cycle still reports the pre-invalidate result.
// - mem_resp_valid outside WAIT is ignored.
// - Reset (any time, including mid-refill):
//   - state=IDLE, all valid=0, mem_req_valid=0, latched address=0.
//   - Hence Hit_cache=0, Miss=1, partial_access=0, partial_type=00, fetched_data=0.
//   - The data and tag arrays are not reset.
// - Odd current_PC (PC[0]=1) is illegal: an immediate assertion reports an error; outputs undefined.
// CONFIGURATION
// - ICACHE_STATS_EN defined: 64-bit internal counters hit_cnt (IDLE hits), miss_cnt (IDLE misses,
//   one per refill) and partial_cnt (partial hits). Reset to 0 and never wrap in practice.
// - ICACHE_STATS_EN undefined: no counters; port list and behaviour are otherwise identical.
// TESTING
// - Reset, PC=0x0, memory ready immediately, resp 2 cycles later with line 0x..1F1E..0100
//   -> Miss=1, mem_req_addr=0x0; Hit_cache=1 after FILL; fetched_data=0x0706050403020100.
// - Line 0 cached, PC=0x1C -> Hit_cache=1, partial_access=1, partial_type=10,
//   fetched_data=0x000000001F1E1D1C.
// - PC=0x1A -> partial_type=11, data=0x00001F1E1D1C1B1A; PC=0x1E -> partial_type=01,
//   data=0x0000000000001F1E; PC=0x18 -> full, partial_type=00.
// - PC=0x0 cached, then PC=0x800 (same index) -> miss, refill addr 0x800; PC back to 0x0 -> miss again.
// - mem_req_ready low for 5 cycles -> mem_req_valid=1 and mem_req_addr stable all 5 cycles, then one
//   handshake.
// - invalidate_all in FILL -> line not valid, next IDLE lookup misses and issues a new request;
//   rst_n pulsed in WAIT -> IDLE, mem_req_valid=0, all lines miss.

Source files
------------

// File: rtl/icache_fetch_responder_if.sv
// ----------------------------------------------------------------------------
// icache_fetch_responder_if
// Fetch-side and refill-side signals of the instruction cache, bundled.
//   current_PC      IF -> cache   fetch address (halfword aligned)
//   invalidate_all  IF -> cache   clear all valid bits (fence.i)
//   Hit_cache/Miss  cache -> IF   lookup result this cycle
//   partial_access  cache -> IF   fetch window crosses the line end
//   partial_type    cache -> IF   valid bytes/2 when partial, else 00
//   fetched_data    cache -> IF   bytes at PC, invalid bytes zero
//   mem_req_*       cache -> mem  line refill request (valid/ready)
//   mem_resp_*      mem -> cache  single-beat line response
// Modports: slave = the cache, master = IF stage plus next memory level.
// ----------------------------------------------------------------------------
interface icache_fetch_responder_if #(
  parameter int unsigned PC_BITS     = 32,
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned LINE_BITS   = 256
);
  logic [PC_BITS-1:0]     current_PC;
  logic                   Hit_cache;
  logic                   Miss;
  logic                   partial_access;
  logic [1:0]             partial_type;
  logic [FETCH_WIDTH-1:0] fetched_data;
  logic                   invalidate_all;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [PC_BITS-1:0]     mem_req_addr;
  logic                   mem_resp_valid;
  logic [LINE_BITS-1:0]   mem_resp_data;

  modport slave (
    input  current_PC, invalidate_all, mem_req_ready, mem_resp_valid, mem_resp_data,
    output Hit_cache, Miss, partial_access, partial_type, fetched_data,
           mem_req_valid, mem_req_addr
  );

  modport master (
    output current_PC, invalidate_all, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  Hit_cache, Miss, partial_access, partial_type, fetched_data,
           mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_fetch_responder.sv
// ----------------------------------------------------------------------------
// icache_fetch_responder
// Direct-mapped, register-array instruction cache answering the IF stage in
// the same cycle. Misses are refilled one line at a time through a
// valid/ready request and a single-beat response (IDLE -> REQ -> WAIT -> FILL).
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (state, valid bits, latched address)
//   bus    icache_fetch_responder_if.slave (fetch lookup + refill channel)
// Optional build macro ICACHE_STATS_EN adds 64-bit hit/miss/partial counters.
// ----------------------------------------------------------------------------
module icache_fetch_responder #(
  parameter int unsigned PC_BITS     = 32,
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned LINE_BITS   = 256,
  parameter int unsigned LINES       = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  icache_fetch_responder_if.slave bus
);
  localparam int unsigned LINE_BYTES  = LINE_BITS / 8;
  localparam int unsigned FETCH_BYTES = FETCH_WIDTH / 8;
  localparam int unsigned OB          = $clog2(LINE_BYTES);
  localparam int unsigned IB          = $clog2(LINES);
  localparam int unsigned TB          = PC_BITS - OB - IB;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LINES-1:0]     r_valid;
  logic [TB-1:0]        r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];
  logic [PC_BITS-1:0]   r_addr;
  logic [LINE_BITS-1:0] r_line;
  logic                 r_inv_pend;

  logic [OB-1:0]          w_off;
  logic [IB-1:0]          w_idx;
  logic [TB-1:0]          w_tag;
  logic [IB-1:0]          w_fill_idx;
  logic [TB-1:0]          w_fill_tag;
  logic                   w_hit;
  logic                   w_miss_idle;
  logic [OB:0]            w_left;
  logic                   w_partial;
  logic [LINE_BITS-1:0]   w_line;
  logic [FETCH_WIDTH-1:0] w_window;
  logic [OB:0]            w_pos;

  assign w_off      = bus.current_PC[OB-1:0];
  assign w_idx      = bus.current_PC[OB +: IB];
  assign w_tag      = bus.current_PC[PC_BITS-1 -: TB];
  assign w_fill_idx = r_addr[OB +: IB];
  assign w_fill_tag = r_addr[PC_BITS-1 -: TB];

  assign w_hit       = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss_idle = (r_state == S_IDLE) && !w_hit;
  assign w_left      = (OB+1)'(LINE_BYTES) - {1'b0, w_off};
  assign w_partial   = w_left < (OB+1)'(FETCH_BYTES);
  assign w_line      = r_data[w_idx];

  // Byte-wise extraction: positions past the line end stay zero, which is
  // exactly the partial-access zero fill.
  always_comb begin
    w_window = '0;
    w_pos    = '0;
    for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
      w_pos = {1'b0, w_off} + (OB+1)'(i);
      if (!w_pos[OB])
        w_window[8*i +: 8] = w_line[{w_pos[OB-1:0], 3'b000} +: 8];
    end
  end

  assign bus.Hit_cache      = w_hit;
  assign bus.Miss           = !w_hit;
  assign bus.partial_access = w_hit && w_partial;
  assign bus.partial_type   = (w_hit && w_partial) ? w_left[2:1] : 2'b00;
  assign bus.fetched_data   = w_hit ? w_window : '0;
  assign bus.mem_req_valid  = (r_state == S_REQ);
  assign bus.mem_req_addr   = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_hit)             w_state_nxt = S_REQ;
      S_REQ:   if (bus.mem_req_ready)  w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid) w_state_nxt = S_FILL;
      S_FILL:                          w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // An invalidate seen while the refill is outstanding is remembered so the
  // line is still written but never marked valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_addr     <= '0;
      r_inv_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss_idle) begin
        r_addr     <= {bus.current_PC[PC_BITS-1:OB], {OB{1'b0}}};
        r_inv_pend <= 1'b0;
      end
      if (bus.invalidate_all) begin
        r_valid <= '0;
        if (r_state == S_REQ || r_state == S_WAIT)
          r_inv_pend <= 1'b1;
      end else if (r_state == S_FILL && !r_inv_pend) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_WAIT && bus.mem_resp_valid)
      r_line <= bus.mem_resp_data;
    if (r_state == S_FILL) begin
      r_data[w_fill_idx] <= r_line;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [63:0] r_hit_cnt;
  logic [63:0] r_miss_cnt;
  logic [63:0] r_partial_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
      r_partial_cnt <= '0;
    end else begin
      if (w_hit)               r_hit_cnt     <= r_hit_cnt + 64'd1;
      if (w_miss_idle)         r_miss_cnt    <= r_miss_cnt + 64'd1;
      if (w_hit && w_partial)  r_partial_cnt <= r_partial_cnt + 64'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

  always_ff @(posedge clk) begin
    if (rst_n)
      assert (bus.current_PC[0] == 1'b0)
        else $error("icache_fetch_responder: odd current_PC %h", bus.current_PC);
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
module tb_icache_fetch_responder;
  localparam int unsigned PC_BITS     = 32;
  localparam int unsigned FETCH_WIDTH = 64;
  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned LINES       = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_fetch_responder_if #(
    .PC_BITS(PC_BITS), .FETCH_WIDTH(FETCH_WIDTH), .LINE_BITS(LINE_BITS)
  ) bus ();

  icache_fetch_responder #(
    .PC_BITS(PC_BITS), .FETCH_WIDTH(FETCH_WIDTH), .LINE_BITS(LINE_BITS), .LINES(LINES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Reference cache state: which line address each index holds.
  bit          m_valid [LINES];
  logic [20:0] m_tag   [LINES];

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        part;
    logic [1:0]  ptype;
    logic [63:0] data;
  } vec_t;
  vec_t vecs [7];

  // Backing memory content: byte at address a (equals a for a < 256).
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return a[7:0] + 8'(a[15:8] * 3) + 8'(a[23:16] * 5) + 8'(a[31:24] * 7);
  endfunction

  function automatic logic [255:0] mline(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = mbyte(base + 32'(i));
    return l;
  endfunction

  function automatic logic [63:0] mwin(input logic [31:0] pc);
    logic [63:0] d;
    int left;
    d = '0;
    left = 32 - int'(pc[4:0]);
    for (int k = 0; k < 8; k++)
      if (k < left) d[k*8 +: 8] = mbyte(pc + 32'(k));
    return d;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[pc[10:5]] && (m_tag[pc[10:5]] == pc[31:11]);
  endfunction

  function automatic logic [31:0] rand_pc();
    int unsigned t;
    logic [20:0] tg;
    t  = $urandom_range(0, 3);
    tg = (t == 3) ? 21'h1ABCDE : 21'(t);
    return {tg, 6'($urandom_range(0, 7)), 5'($urandom_range(0, 15) * 2)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.invalidate_all = 1'b0;
  endtask

  task automatic chk_lookup(input string nm);
    logic [31:0] pc;
    bit          eh;
    int          left;
    pc = bus.current_PC;
    eh = m_hit(pc);
    chk({nm, "_hit"}, 64'(bus.Hit_cache), 64'(eh));
    chk({nm, "_miss"}, 64'(bus.Miss), 64'(!eh));
    if (eh) begin
      left = 32 - int'(pc[4:0]);
      chk({nm, "_part"}, 64'(bus.partial_access), 64'(left < 8));
      chk({nm, "_ptype"}, 64'(bus.partial_type), (left < 8) ? 64'(left / 2) : 64'd0);
      chk({nm, "_data"}, bus.fetched_data, mwin(pc));
    end
  endtask

  // Entered in the miss cycle; returns in the first IDLE cycle after FILL.
  // inv_phase: 0 none, 1 invalidate in REQ, 2 in WAIT, 3 in FILL.
  task automatic serve(input int rlat, input int plat, input int inv_phase, input bit wander);
    logic [31:0] la;
    la = {bus.current_PC[31:5], 5'b0};
    tick();
    chk("req_nohit", 64'(bus.Hit_cache), 64'd0);
    if (wander) bus.current_PC = rand_pc();
    if (inv_phase == 1) bus.invalidate_all = 1'b1;
    for (int k = 0; k < rlat; k++) begin
      chk("req_valid_hold", 64'(bus.mem_req_valid), 64'd1);
      chk("req_addr_hold", 64'(bus.mem_req_addr), 64'(la));
      tick();
    end
    bus.mem_req_ready = 1'b1;
    chk("req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("req_addr", 64'(bus.mem_req_addr), 64'(la));
    tick();
    bus.mem_req_ready = 1'b0;
    chk("wait_noreq", 64'(bus.mem_req_valid), 64'd0);
    if (inv_phase == 2) bus.invalidate_all = 1'b1;
    for (int k = 0; k < plat - 1; k++) tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = mline(la);
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = {8{$urandom()}};
    if (inv_phase == 3) bus.invalidate_all = 1'b1;
    tick();
    if (inv_phase != 0) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else begin
      m_valid[la[10:5]] = 1'b1;
      m_tag[la[10:5]]   = la[31:11];
    end
  endtask

  initial begin
    bus.current_PC     = '0;
    bus.invalidate_all = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;

    vecs[0] = '{32'h00, 1'b1, 1'b0, 2'd0, 64'h0706050403020100};
    vecs[1] = '{32'h1C, 1'b1, 1'b1, 2'd2, 64'h000000001F1E1D1C};
    vecs[2] = '{32'h1A, 1'b1, 1'b1, 2'd3, 64'h00001F1E1D1C1B1A};
    vecs[3] = '{32'h1E, 1'b1, 1'b1, 2'd1, 64'h0000000000001F1E};
    vecs[4] = '{32'h18, 1'b1, 1'b0, 2'd0, 64'h1F1E1D1C1B1A1918};
    vecs[5] = '{32'h10, 1'b1, 1'b0, 2'd0, 64'h1716151413121110};
    vecs[6] = '{32'h02, 1'b1, 1'b0, 2'd0, 64'h0908070605040302};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit",  64'(bus.Hit_cache), 64'd0);
    chk("rst_miss", 64'(bus.Miss), 64'd1);
    chk("rst_part", 64'(bus.partial_access), 64'd0);
    chk("rst_type", 64'(bus.partial_type), 64'd0);
    chk("rst_data", bus.fetched_data, 64'd0);
    chk("rst_reqv", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_addr", 64'(bus.mem_req_addr), 64'd0);
    rst_n = 1'b1;
    #1;

    // First miss on line 0, ready immediately, response 2 cycles later
    chk_lookup("first");
    serve(0, 2, 0, 1'b0);
    chk_lookup("fill0");
    chk("fill0_const", bus.fetched_data, 64'h0706050403020100);

    // Table of lookups within cached line 0
    for (int i = 0; i < 7; i++) begin
      bus.current_PC = vecs[i].pc;
      #1;
      chk("tbl_hit",   64'(bus.Hit_cache), 64'(vecs[i].hit));
      chk("tbl_miss",  64'(bus.Miss), 64'(!vecs[i].hit));
      chk("tbl_part",  64'(bus.partial_access), 64'(vecs[i].part));
      chk("tbl_ptype", 64'(bus.partial_type), 64'(vecs[i].ptype));
      chk("tbl_data",  bus.fetched_data, vecs[i].data);
      tick();
    end

    // Conflict at same index, request held 5 cycles before ready
    bus.current_PC = 32'h800;
    #1;
    chk_lookup("conf800");
    serve(5, 1, 0, 1'b0);
    chk_lookup("conf800_hit");
    bus.current_PC = 32'h0;
    #1;
    chk_lookup("conf0");
    chk("conf0_miss", 64'(bus.Miss), 64'd1);
    serve(1, 2, 0, 1'b1);

    // Invalidate during FILL discards the line; next lookup re-requests
    bus.current_PC = 32'h40;
    #1;
    chk_lookup("invf");
    serve(0, 1, 3, 1'b0);
    bus.current_PC = 32'h40;
    #1;
    chk_lookup("invf_after");
    serve(0, 1, 0, 1'b0);
    chk_lookup("invf_refill");

    // Invalidate during WAIT with PC wandering: refill completes, stays invalid
    bus.current_PC = 32'h60;
    #1;
    chk_lookup("invw");
    serve(2, 3, 2, 1'b1);
    bus.current_PC = 32'h60;
    #1;
    chk_lookup("invw_after");
    serve(0, 1, 0, 1'b0);

    // Stray response in IDLE is ignored
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = {8{$urandom()}};
    #1;
    chk_lookup("stray");
    tick();
    bus.mem_resp_valid = 1'b0;
    chk_lookup("stray_after");

    // Invalidate on a hit cycle reports the pre-invalidate result
    bus.invalidate_all = 1'b1;
    #1;
    chk_lookup("invh");
    tick();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    chk_lookup("invh_after");
    serve(0, 1, 0, 1'b0);

    // Reset pulsed while waiting for the response
    bus.current_PC = 32'h80;
    #1;
    chk_lookup("rstw");
    tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    bus.current_PC = 32'h60;
    #1;
    chk("rstw_reqv", 64'(bus.mem_req_valid), 64'd0);
    chk("rstw_addr", 64'(bus.mem_req_addr), 64'd0);
    chk("rstw_hit",  64'(bus.Hit_cache), 64'd0);
    chk("rstw_miss", 64'(bus.Miss), 64'd1);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk_lookup("rstw_after");
    serve(0, 1, 0, 1'b0);

    // Randomized traffic against the reference model
    repeat (300) begin
      logic [31:0] pc;
      bit          eh;
      bit          inv;
      pc  = rand_pc();
      eh  = m_hit(pc);
      inv = eh && ($urandom_range(0, 9) == 0);
      bus.current_PC     = pc;
      bus.invalidate_all = inv;
      #1;
      chk_lookup("rnd");
      if (eh) begin
        tick();
        if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
      end else begin
        serve(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
              ($urandom_range(0, 7) > 5) ? int'($urandom_range(1, 3)) : 0,
              1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
